// File: rtl/axi_ram_slave_if.sv
// AXI3-style bus bundle for the RAM slave: read address/data, write
// address/data and write response channels. Clock and reset stay outside.
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// Word-addressed 32-bit RAM behind an AXI slave port. Independent read and
// write engines, one burst each in flight, every burst treated as INCR of
// 4-byte words. Upper address bits alias; size/burst type are ignored.
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_DELAY   = 0
) (
  input logic            clk,
  input logic            reset,
  axi_ram_slave_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Wait counter preload: R_WAIT lasts exactly RD_DELAY cycles
  localparam logic [2:0] WAIT_INIT = (RD_DELAY > 0) ? 3'(RD_DELAY - 1) : 3'd0;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t              r_state;
  logic [3:0]            r_id;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_wait;

  w_state_t              w_state;
  logic [3:0]            w_id;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic                  w_err;

  logic        ar_fire;
  logic        aw_fire;
  logic        w_fire;
  logic        r_active;
  logic        b_active;
  logic [31:0] mem_rd;

  // Handshake qualifiers; reset gates every valid/ready combinationally
  assign bus.arready = (r_state == R_IDLE) & ~reset;
  assign bus.awready = (w_state == W_IDLE) & ~reset;
  assign bus.wready  = (w_state == W_DATA) & ~reset;
  assign r_active    = (r_state == R_DATA) & ~reset;
  assign b_active    = (w_state == W_RESP) & ~reset;

  assign ar_fire = bus.arvalid & bus.arready;
  assign aw_fire = bus.awvalid & bus.awready;
  assign w_fire  = bus.wvalid & bus.wready;

  // Read channel outputs are forced to zero whenever no beat is offered
  assign bus.rvalid = r_active;
  assign bus.rid    = r_active ? r_id : 4'd0;
  assign bus.rdata  = r_active ? mem_rd : 32'd0;
  assign bus.rlast  = r_active & (r_beat == r_len);
  assign bus.rresp  = 2'b00;

  assign bus.bvalid = b_active;
  assign bus.bid    = b_active ? w_id : 4'd0;
  assign bus.bresp  = (b_active && w_err) ? 2'b10 : 2'b00;

  // Read engine: capture AR, optional fixed delay, then stream beats
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_id    <= bus.arid;
            r_idx   <= bus.araddr[ADDR_WIDTH+1:2];
            r_len   <= bus.arlen;
            r_beat  <= '0;
            r_wait  <= WAIT_INIT;
            r_state <= (RD_DELAY > 0) ? R_WAIT : R_DATA;
          end
        end
        R_WAIT: begin
          if (r_wait == 3'd0) r_state <= R_DATA;
          else                r_wait  <= r_wait - 3'd1;
        end
        R_DATA: begin
          if (bus.rready) begin
            r_idx  <= r_idx + 1'b1;
            r_beat <= r_beat + 8'd1;
            if (r_beat == r_len) r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write engine: W is only accepted after AW; burst length comes from
  // awlen, a misplaced wlast merely flags SLVERR in the response
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            w_id    <= bus.awid;
            w_idx   <= bus.awaddr[ADDR_WIDTH+1:2];
            w_len   <= bus.awlen;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wvalid) begin
            w_idx  <= w_idx + 1'b1;
            w_beat <= w_beat + 8'd1;
            if (bus.wlast != (w_beat == w_len)) w_err <= 1'b1;
            if (w_beat == w_len) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // One byte-wide memory per lane so strobes map onto independent RAMs;
  // the read port is asynchronous so a same-edge write shows up next cycle
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte-lane write on an accepted W beat with its strobe set
      always_ff @(posedge clk) begin
        if (w_fire && bus.wstrb[gi]) lane_mem[w_idx] <= bus.wdata[gi*8 +: 8];
      end

      assign mem_rd[gi*8 +: 8] = lane_mem[r_idx];
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{bus.arsize, bus.arburst, bus.awsize, bus.awburst, bus.wid,
                         bus.araddr[31:ADDR_WIDTH+2], bus.araddr[1:0],
                         bus.awaddr[31:ADDR_WIDTH+2], bus.awaddr[1:0]};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: one instance with no read delay and a
// second with RD_DELAY=3; a shared master drives whichever one sel picks.
module tb_axi_ram_slave;
  logic clk = 1'b0;
  logic reset;
  logic sel;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_ram_slave_if bus0();
  axi_ram_slave_if bus3();

  axi_ram_slave #(.ADDR_WIDTH(10), .RD_DELAY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  axi_ram_slave #(.ADDR_WIDTH(4),  .RD_DELAY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  logic [3:0]  m_arid, m_awid;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [3:0]  m_wstrb;
  logic        m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;

  assign bus0.arid = m_arid;     assign bus3.arid = m_arid;
  assign bus0.araddr = m_araddr; assign bus3.araddr = m_araddr;
  assign bus0.arlen = m_arlen;   assign bus3.arlen = m_arlen;
  assign bus0.arsize = 3'd2;     assign bus3.arsize = 3'd2;
  assign bus0.arburst = 2'b01;   assign bus3.arburst = 2'b01;
  assign bus0.awid = m_awid;     assign bus3.awid = m_awid;
  assign bus0.awaddr = m_awaddr; assign bus3.awaddr = m_awaddr;
  assign bus0.awlen = m_awlen;   assign bus3.awlen = m_awlen;
  assign bus0.awsize = 3'd2;     assign bus3.awsize = 3'd2;
  assign bus0.awburst = 2'b01;   assign bus3.awburst = 2'b01;
  assign bus0.wid = 4'hF;        assign bus3.wid = 4'hF;
  assign bus0.wdata = m_wdata;   assign bus3.wdata = m_wdata;
  assign bus0.wstrb = m_wstrb;   assign bus3.wstrb = m_wstrb;
  assign bus0.wlast = m_wlast;   assign bus3.wlast = m_wlast;
  assign bus0.arvalid = m_arvalid & ~sel; assign bus3.arvalid = m_arvalid & sel;
  assign bus0.awvalid = m_awvalid & ~sel; assign bus3.awvalid = m_awvalid & sel;
  assign bus0.wvalid  = m_wvalid & ~sel;  assign bus3.wvalid  = m_wvalid & sel;
  assign bus0.rready  = m_rready & ~sel;  assign bus3.rready  = m_rready & sel;
  assign bus0.bready  = m_bready & ~sel;  assign bus3.bready  = m_bready & sel;

  logic        s_arready, s_awready, s_wready, s_rvalid, s_rlast, s_bvalid;
  logic [3:0]  s_rid, s_bid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  assign s_arready = sel ? bus3.arready : bus0.arready;
  assign s_awready = sel ? bus3.awready : bus0.awready;
  assign s_wready  = sel ? bus3.wready  : bus0.wready;
  assign s_rvalid  = sel ? bus3.rvalid  : bus0.rvalid;
  assign s_rlast   = sel ? bus3.rlast   : bus0.rlast;
  assign s_rid     = sel ? bus3.rid     : bus0.rid;
  assign s_rdata   = sel ? bus3.rdata   : bus0.rdata;
  assign s_rresp   = sel ? bus3.rresp   : bus0.rresp;
  assign s_bvalid  = sel ? bus3.bvalid  : bus0.bvalid;
  assign s_bid     = sel ? bus3.bid     : bus0.bid;
  assign s_bresp   = sel ? bus3.bresp   : bus0.bresp;

  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic [31:0] rexp [8];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All helpers start and end on a negedge
  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    m_araddr = addr; m_arlen = len; m_arid = id; m_arvalid = 1'b1;
    while (!s_arready && n < 64) begin @(negedge clk); n++; end
    check_value("arready_seen", 32'(s_arready), 32'd1);
    @(negedge clk);
    m_arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    m_awaddr = addr; m_awlen = len; m_awid = id; m_awvalid = 1'b1;
    while (!s_awready && n < 64) begin @(negedge clk); n++; end
    check_value("awready_seen", 32'(s_awready), 32'd1);
    @(negedge clk);
    m_awvalid = 1'b0;
  endtask

  task automatic do_write(input logic s, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input int bad_beat, input logic [1:0] resp);
    int n;
    sel = s;
    aw_send(addr, len, id);
    for (int i = 0; i <= int'(len); i++) begin
      m_wdata = wd[i]; m_wstrb = ws[i];
      m_wlast = (i == int'(len)) ^ (i == bad_beat);
      m_wvalid = 1'b1;
      n = 0;
      while (!s_wready && n < 64) begin @(negedge clk); n++; end
      check_value("wready_seen", 32'(s_wready), 32'd1);
      @(negedge clk);
    end
    m_wvalid = 1'b0;
    m_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < 64) begin @(negedge clk); n++; end
    check_value("bvalid", 32'(s_bvalid), 32'd1);
    check_value("bid", 32'(s_bid), 32'(id));
    check_value("bresp", 32'(s_bresp), 32'(resp));
    @(negedge clk);
    m_bready = 1'b0;
    $display("write sel=%0d addr=%h len=%0d id=%0d bresp=%0d", s, addr, len, id, resp);
  endtask

  task automatic do_read(input logic s, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic stall);
    int n = 0;
    sel = s;
    m_rready = 1'b0;
    ar_send(addr, len, id);
    while (!s_rvalid && n < 64) begin @(negedge clk); n++; end
    check_value("rd_latency", 32'(n), s ? 32'd3 : 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      check_value("rvalid", 32'(s_rvalid), 32'd1);
      check_value("rdata", s_rdata, rexp[i]);
      check_value("rlast", 32'(s_rlast), 32'(i == int'(len)));
      check_value("rid", 32'(s_rid), 32'(id));
      check_value("rresp", 32'(s_rresp), 32'd0);
      if (stall) begin
        m_rready = 1'b0;
        @(negedge clk);
        check_value("rvalid_stall", 32'(s_rvalid), 32'd1);
        check_value("rdata_stall", s_rdata, rexp[i]);
        check_value("rlast_stall", 32'(s_rlast), 32'(i == int'(len)));
      end
      m_rready = 1'b1;
      @(negedge clk);
    end
    m_rready = 1'b0;
    check_value("rvalid_end", 32'(s_rvalid), 32'd0);
    $display("read sel=%0d addr=%h len=%0d id=%0d stall=%0d", s, addr, len, id, stall);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0; reset = 1'b1;
    m_arid = '0; m_awid = '0; m_araddr = '0; m_awaddr = '0; m_wdata = '0;
    m_arlen = '0; m_awlen = '0; m_wstrb = '0;
    m_arvalid = 0; m_awvalid = 0; m_wvalid = 0; m_wlast = 0; m_rready = 0; m_bready = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check_value("rst_arready", 32'(s_arready), 32'd0);
    check_value("rst_awready", 32'(s_awready), 32'd0);
    check_value("rst_wready", 32'(s_wready), 32'd0);
    check_value("rst_rvalid", 32'(s_rvalid), 32'd0);
    check_value("rst_bvalid", 32'(s_bvalid), 32'd0);
    check_value("rst_rdata", s_rdata, 32'd0);
    check_value("rst_bid", 32'(s_bid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_value("post_rst_arready", 32'(s_arready), 32'd1);
    check_value("post_rst_awready", 32'(s_awready), 32'd1);
    $display("reset released");

    // Single write then read; 0x1000 aliases onto word 0
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(0, 32'h1000, 8'd0, 4'd1, -1, 2'b00);
    rexp[0] = 32'hDEADBEEF;
    do_read(0, 32'h1000, 8'd0, 4'd0, 0);
    do_read(0, 32'h0000, 8'd0, 4'd2, 0);

    // Four-beat burst, read back with rready stalls
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'hF;
    do_write(0, 32'h20, 8'd3, 4'd2, -1, 2'b00);
    rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
    do_read(0, 32'h20, 8'd3, 4'd3, 1);

    // Byte strobes
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    do_write(0, 32'h40, 8'd0, 4'd4, -1, 2'b00);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_write(0, 32'h40, 8'd0, 4'd4, -1, 2'b00);
    rexp[0] = 32'hAA22CC44;
    do_read(0, 32'h40, 8'd0, 4'd4, 0);

    // Early wlast: both beats land, SLVERR; next clean burst is OKAY
    wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(0, 32'h60, 8'd1, 4'd5, 0, 2'b10);
    rexp[0] = 32'h55; rexp[1] = 32'h66;
    do_read(0, 32'h60, 8'd1, 4'd5, 0);
    wd[0] = 32'h77; wd[1] = 32'h88;
    do_write(0, 32'h60, 8'd1, 4'd5, -1, 2'b00);
    rexp[0] = 32'h77; rexp[1] = 32'h88;
    do_read(0, 32'h60, 8'd1, 4'd5, 0);

    // AW and W presented together; bready held off for three cycles
    sel = 1'b0;
    m_awaddr = 32'hA0; m_awlen = 8'd0; m_awid = 4'd7; m_awvalid = 1'b1;
    m_wdata = 32'h12345678; m_wstrb = 4'hF; m_wlast = 1'b1; m_wvalid = 1'b1;
    check_value("bo_wready_early", 32'(s_wready), 32'd0);
    @(negedge clk);
    m_awvalid = 1'b0;
    check_value("bo_wready_after_aw", 32'(s_wready), 32'd1);
    @(negedge clk);
    m_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_value("bo_bvalid_hold", 32'(s_bvalid), 32'd1);
      check_value("bo_bid_hold", 32'(s_bid), 32'd7);
      @(negedge clk);
    end
    m_bready = 1'b1;
    check_value("bo_bvalid", 32'(s_bvalid), 32'd1);
    @(negedge clk);
    m_bready = 1'b0;
    check_value("bo_bvalid_done", 32'(s_bvalid), 32'd0);
    check_value("bo_bid_zero", 32'(s_bid), 32'd0);
    $display("bridge order write done");
    rexp[0] = 32'h12345678;
    do_read(0, 32'hA0, 8'd0, 4'd7, 0);

    // Same-edge read and write of one word: old data now, new data after
    wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
    do_write(0, 32'h80, 8'd0, 4'd9, -1, 2'b00);
    aw_send(32'h80, 8'd0, 4'd9);
    ar_send(32'h80, 8'd0, 4'd4);
    m_wdata = 32'hCAFEBABE; m_wstrb = 4'hF; m_wlast = 1'b1; m_wvalid = 1'b1;
    m_rready = 1'b1;
    check_value("rw_rvalid", 32'(s_rvalid), 32'd1);
    check_value("rw_wready", 32'(s_wready), 32'd1);
    check_value("rw_old_data", s_rdata, 32'h0BADF00D);
    @(negedge clk);
    m_wvalid = 1'b0; m_rready = 1'b0; m_bready = 1'b1;
    check_value("rw_bvalid", 32'(s_bvalid), 32'd1);
    @(negedge clk);
    m_bready = 1'b0;
    $display("same-cycle read/write done");
    rexp[0] = 32'hCAFEBABE;
    do_read(0, 32'h80, 8'd0, 4'd4, 0);

    // RD_DELAY=3 instance: latency, then reset during beat 2
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'hF;
    do_write(1, 32'h0, 8'd3, 4'd6, -1, 2'b00);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    sel = 1'b1;
    ar_send(32'h0, 8'd3, 4'd6);
    for (int k = 0; k < 3; k++) begin
      check_value("d3_wait_rvalid", 32'(s_rvalid), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check_value("d3_rvalid", 32'(s_rvalid), 32'd1);
      check_value("d3_rdata", s_rdata, rexp[i]);
      m_rready = 1'b1;
      @(negedge clk);
    end
    m_rready = 1'b0;
    check_value("d3_beat2", s_rdata, rexp[2]);
    reset = 1'b1;
    @(negedge clk);
    check_value("d3_rst_rvalid", 32'(s_rvalid), 32'd0);
    check_value("d3_rst_rdata", s_rdata, 32'd0);
    check_value("d3_rst_arready", 32'(s_arready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_value("d3_post_arready", 32'(s_arready), 32'd1);
    check_value("d3_post_rvalid", 32'(s_rvalid), 32'd0);
    $display("reset mid-burst done");
    do_read(1, 32'h0, 8'd3, 4'd6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, number of word-address bits (memory = 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter RD_DELAY, default 0, idle cycles between AR handshake and first R beat (legal range 0..7).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on posedge); reset input 1 (synchronous, active-high).
REQ-004 SHALL have these read-address ports: arid input 4; araddr input 32; arlen input 8; arsize input 3; arburst input 2; arvalid input 1; arready output 1.
REQ-005 SHALL have these read-data ports: rid output 4; rdata output 32; rresp output 2; rlast output 1; rvalid output 1; rready input 1.
REQ-006 SHALL have these write-address ports: awid input 4; awaddr input 32; awlen input 8; awsize input 3; awburst input 2; awvalid input 1; awready output 1.
REQ-007 SHALL have these write-data ports: wid input 4; wdata input 32; wstrb input 4; wlast input 1; wvalid input 1; wready output 1.
REQ-008 SHALL have these write-response ports: bid output 4; bresp output 2; bvalid output 1; bready input 1.

Function
REQ-009 SHALL run independent read and write FSMs: one outstanding read and one outstanding write at a time.
REQ-010 SHALL map word index = addr[ADDR_WIDTH+1:2], ignore upper address bits (aliasing), and ignore arsize/awsize/arburst/awburst (every burst is INCR of 4-byte words).
REQ-011 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; arready = (state==R_IDLE) & ~reset.
REQ-012 On arvalid&arready the block SHALL capture arid, word index and arlen, then enter R_WAIT if RD_DELAY>0 (for exactly RD_DELAY cycles), else R_DATA.
REQ-013 In R_DATA: rvalid=1, rid=captured id, rresp=2'b00, rdata=mem[current index] combinationally, rlast=1 only on beat number arlen (beats counted 0..arlen).
REQ-014 Each rvalid&rready SHALL increment index modulo 2^ADDR_WIDTH; rdata, rlast, rid SHALL hold stable while rvalid&~rready.
REQ-015 Handshake on the last beat SHALL return to R_IDLE; arready SHALL be 1 the following cycle.
REQ-016 When rvalid=0, rdata, rid and rlast SHALL be 0.
REQ-017 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready = (state==W_IDLE) & ~reset; wready = (state==W_DATA).
REQ-018 wvalid arriving before or with awvalid SHALL wait; wready SHALL never assert before the AW handshake.
REQ-019 On awvalid&awready the block SHALL capture awid, index, awlen; clear the beat counter and the error flag; enter W_DATA.
REQ-020 Each wvalid&wready SHALL write bytes of wdata where wstrb[i]=1 into mem[index] at that clock edge, then increment index (modulo).
REQ-021 If wlast differs from (beat==awlen) on any beat, the error flag SHALL set; data SHALL still be written; the burst SHALL always end at beat awlen.
REQ-022 After the last beat the block SHALL enter W_RESP: bvalid=1, bid=captured id, bresp = error ? 2'b10 : 2'b00, held until bready; bvalid&bready -> W_IDLE.
REQ-023 When bvalid=0, bid and bresp SHALL be 0; wid SHALL be ignored.
REQ-024 A same-cycle read and write of one word SHALL return old data on rdata; the new data SHALL be visible from the next cycle.
REQ-025 arlen/awlen up to 255 SHALL be supported; the beat counter SHALL be 8 bits.

Reset
REQ-026 While reset=1: both FSMs idle, arready=awready=wready=rvalid=rlast=bvalid=0, rid=bid=0, rdata=0, rresp=bresp=0.
REQ-027 Reset mid-burst SHALL abort both transactions with no response issued; memory contents SHALL be retained.
REQ-028 arready and awready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-029 Single write then read: AW 0x1000/len0/id1, W 0xDEADBEEF strb F wlast1 -> bvalid, bid1, bresp 00; AR 0x1000 id0 -> one beat rdata 0xDEADBEEF, rlast1, rid0.
REQ-030 4-beat burst: AW 0x20 len3, W 0x11,0x22,0x33,0x44 (wlast on 4th); AR 0x20 len3 with rready toggling 1,0,1,0.. -> beats 0x11..0x44 in order, rlast only on 4th, data stable during stalls.
REQ-031 Byte strobes: mem[0x40]=0xAABBCCDD; write 0x11223344 strb 4'b0101 -> read 0xAA22CC44.
REQ-032 wlast error: len1 burst with wlast on beat 0 -> both beats written, bresp 2'b10; the next correct burst returns bresp 00.
REQ-033 Bridge order: awvalid and wvalid asserted same cycle -> wready=0 that cycle, W accepted after the AW handshake; bready held low 3 cycles -> bvalid, bid stable.
REQ-034 RD_DELAY=3: AR handshake at cycle n -> first rvalid at cycle n+4; reset asserted during beat 2 of a len3 read -> rvalid=0 next cycle, arready=1 after reset, memory unchanged.
